// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and BCD digit width for the stopwatch
package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler issuing one TICK every CNT_FULL enabled cycles
// The count is held while EN is low so a paused period resumes where it stopped.
module tick_gen #(
  parameter int CNT_FULL = 100_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic TICK
);

  localparam int CW = (CNT_FULL > 1) ? $clog2(CNT_FULL) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(CNT_FULL - 1));
  assign TICK   = EN & w_last;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (EN) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - BCD stopwatch with start/stop, hold-clear and lap capture
// Lap capture is built only when STOPWATCH_LAP_EN is defined; otherwise LAP_VAL is 0.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int CNT_FULL = 100_000_000,
  parameter int DIGITS   = 4,
  parameter int WRAP     = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    BTN_SS,
  input  logic                    BTN_LAP,
  output logic [BCD_W*DIGITS-1:0] VAL,
  output logic [BCD_W*DIGITS-1:0] LAP_VAL,
  output logic                    RUN,
  output logic                    OVF
);

  localparam int W = BCD_W * DIGITS;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_val;
  logic [W-1:0]   w_val_nxt;
  logic [W-1:0]   w_val_inc;
  logic           r_ovf;
  logic           w_ovf_nxt;
  logic           r_ss_d;
  logic           r_lap_d;
  logic           w_ss_e;
  logic           w_lap_e;
  logic           w_carry;
  logic           w_clr;
  logic           w_tick;

  // Start/stop wins a same-cycle collision, so the lap edge is dropped.
  assign w_ss_e  = BTN_SS & ~r_ss_d;
  assign w_lap_e = BTN_LAP & ~r_lap_d & ~w_ss_e;

  assign w_clr = ((r_state == S_HOLD) & w_lap_e) |
                 ((r_state != S_IDLE) & (r_state != S_RUN) & (r_state != S_HOLD));

  tick_gen #(
    .CNT_FULL(CNT_FULL)
  ) u_tick_gen (
    .CLK (CLK),
    .RST (RST | w_clr),
    .EN  (r_state == S_RUN),
    .TICK(w_tick)
  );

  // Ripple BCD increment; w_carry left high means every digit was 9.
  always_comb begin
    w_val_inc = r_val;
    w_carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_val[i*BCD_W +: BCD_W] == BCD_W'(9)) begin
          w_val_inc[i*BCD_W +: BCD_W] = '0;
        end else begin
          w_val_inc[i*BCD_W +: BCD_W] = r_val[i*BCD_W +: BCD_W] + BCD_W'(1);
          w_carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_val_nxt   = r_val;
    w_ovf_nxt   = r_ovf;
    if (w_tick) begin
      if (w_carry) begin
        w_ovf_nxt = 1'b1;
        w_val_nxt = (WRAP != 0) ? '0 : r_val;
      end else begin
        w_val_nxt = w_val_inc;
      end
    end
    case (r_state)
      S_IDLE: if (w_ss_e) w_state_nxt = S_RUN;
      S_RUN:  if (w_ss_e) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (w_ss_e) begin
          w_state_nxt = S_RUN;
        end else if (w_lap_e) begin
          w_state_nxt = S_IDLE;
          w_val_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_val_nxt   = '0;
        w_ovf_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_val   <= '0;
      r_ovf   <= 1'b0;
      r_ss_d  <= 1'b0;
      r_lap_d <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_val   <= w_val_nxt;
      r_ovf   <= w_ovf_nxt;
      r_ss_d  <= BTN_SS;
      r_lap_d <= BTN_LAP;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] r_lap_val;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lap_val <= '0;
    end else if ((r_state == S_RUN) && w_lap_e) begin
      r_lap_val <= r_val;
    end
  end

  assign LAP_VAL = r_lap_val;
`else
  assign LAP_VAL = '0;
`endif

  assign VAL = r_val;
  assign RUN = (r_state == S_RUN);
  assign OVF = r_ovf;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb/tb_stopwatch_bcd.sv - bench for stopwatch_bcd, wrap and saturate builds side by side
module tb_stopwatch_bcd;

  localparam int CF   = 4;
  localparam int DIG  = 2;
  localparam int MAXV = 99;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_SS = 1'b0;
  logic       BTN_LAP = 1'b0;
  logic [7:0] val_w, lap_w, val_s, lap_s;
  logic       run_w, ovf_w, run_s, ovf_s;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  stopwatch_bcd #(.CNT_FULL(CF), .DIGITS(DIG), .WRAP(1)) u_wrap (
    .CLK(CLK), .RST(RST), .BTN_SS(BTN_SS), .BTN_LAP(BTN_LAP),
    .VAL(val_w), .LAP_VAL(lap_w), .RUN(run_w), .OVF(ovf_w)
  );

  stopwatch_bcd #(.CNT_FULL(CF), .DIGITS(DIG), .WRAP(0)) u_sat (
    .CLK(CLK), .RST(RST), .BTN_SS(BTN_SS), .BTN_LAP(BTN_LAP),
    .VAL(val_s), .LAP_VAL(lap_s), .RUN(run_s), .OVF(ovf_s)
  );

  // Behavioural reference: decimal integer count, state 0=idle 1=run 2=hold.
  typedef struct {
    int st;
    int pre;
    int cnt;
    bit ovf;
    int lap;
  } mdl_t;

  typedef struct packed {
    logic       run;
    logic       ovf;
    logic [7:0] val;
    logic [7:0] lap;
  } obs_t;

  mdl_t mw, ms;
  bit   prev_ss, prev_lap;
  obs_t q_w[$];
  obs_t q_s[$];

  function automatic logic [7:0] to_bcd(input int x);
    logic [7:0] r;
    int v;
    v = x;
    r = '0;
    for (int i = 0; i < DIG; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit sse, input bit lape, input bit wrap);
    mdl_t n;
    bit tick;
    n = m;
    tick = (m.st == 1) && (m.pre == CF - 1);
    if (m.st == 1) n.pre = tick ? 0 : m.pre + 1;
`ifdef STOPWATCH_LAP_EN
    if (m.st == 1 && lape) n.lap = m.cnt;
`endif
    if (tick) begin
      if (m.cnt == MAXV) begin
        n.ovf = 1'b1;
        n.cnt = wrap ? 0 : MAXV;
      end else begin
        n.cnt = m.cnt + 1;
      end
    end
    if (sse) begin
      n.st = (m.st == 1) ? 2 : 1;
    end else if (lape && m.st == 2) begin
      n.st = 0; n.cnt = 0; n.pre = 0; n.ovf = 1'b0;
    end
    return n;
  endfunction

  function automatic obs_t exp_of(input mdl_t m);
    obs_t o;
    o.run = (m.st == 1);
    o.ovf = m.ovf;
    o.val = to_bcd(m.cnt);
    o.lap = to_bcd(m.lap);
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare both DUTs after the edge.
  task automatic cyc(input bit rst, input bit ss, input bit lap);
    bit   sse, lape;
    obs_t ew, es, ow, os;
    RST = rst; BTN_SS = ss; BTN_LAP = lap;
    if (rst) begin
      mw = '{default: 0};
      ms = '{default: 0};
      prev_ss = 1'b0;
      prev_lap = 1'b0;
    end else begin
      sse  = ss && !prev_ss;
      lape = lap && !prev_lap && !sse;
      mw = mstep(mw, sse, lape, 1'b1);
      ms = mstep(ms, sse, lape, 1'b0);
      prev_ss = ss;
      prev_lap = lap;
    end
    q_w.push_back(exp_of(mw));
    q_s.push_back(exp_of(ms));
    @(posedge CLK);
    #1;
    ew = q_w.pop_front();
    es = q_s.pop_front();
    ow = {run_w, ovf_w, val_w, lap_w};
    os = {run_s, ovf_s, val_s, lap_s};
    checks++;
    assert (ow === ew) else begin
      failures++;
      $error("FAIL cycle_wrap {run,ovf,val,lap} observed=%h expected=%h", ow, ew);
    end
    checks++;
    assert (os === es) else begin
      failures++;
      $error("FAIL cycle_sat {run,ovf,val,lap} observed=%h expected=%h", os, es);
    end
  endtask

  initial begin
    logic [7:0] lap_exp;

    // reset and basic counting
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("reset_val", val_w, 8'h00);
    chk("reset_run", run_w, 1'b0);
    cyc(0, 0, 1);
    chk("lap_in_idle_ignored", run_w, 1'b0);
    cyc(0, 1, 0);
    chk("run_after_edge", run_w, 1'b1);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0);
    chk("val_after_10_ticks", val_w, 8'h10);

    // held start/stop gives one event
    cyc(1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0);
    chk("held_ss_single_run", run_w, 1'b1);
    cyc(0, 0, 0);

    // full scale: wrap vs saturate
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 1000 && mw.cnt != MAXV; i++) cyc(0, 0, 0);
    chk("reach_99", val_w, 8'h99);
    for (int i = 0; i < CF; i++) cyc(0, 0, 0);
    chk("wrap_val", val_w, 8'h00);
    chk("wrap_ovf", ovf_w, 1'b1);
    chk("sat_val", val_s, 8'h99);
    chk("sat_ovf", ovf_s, 1'b1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0);
    chk("sat_ticks_ignored", val_s, 8'h99);
    chk("wrap_ovf_sticky", ovf_w, 1'b1);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("clear_ovf", ovf_w, 1'b0);
    chk("clear_val", val_s, 8'h00);
    chk("clear_idle", run_w, 1'b0);

    // partial prescaler period survives a hold
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("hold_entered", run_w, 1'b0);
    for (int i = 0; i < 50; i++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("resume_no_tick_yet", val_w, 8'h00);
    cyc(0, 0, 0);
    chk("resume_tick_2_cycles", val_w, 8'h01);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    chk("hold_clear_val", val_w, 8'h00);

    // lap capture on the tick cycle takes the pre-increment value
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 1000 && !(mw.cnt == 37 && mw.pre == CF - 1); i++) cyc(0, 0, 0);
    cyc(0, 0, 1);
`ifdef STOPWATCH_LAP_EN
    lap_exp = 8'h37;
`else
    lap_exp = 8'h00;
`endif
    chk("lap_capture", lap_w, lap_exp);
    chk("val_after_lap_tick", val_w, 8'h38);
    cyc(0, 0, 0);
    cyc(0, 1, 1);
    chk("ss_priority_hold", run_w, 1'b0);
    chk("ss_priority_lap_kept", lap_w, lap_exp);

    // reset beats a same-cycle start/stop edge mid-count
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("rst_val", val_w, 8'h00);
    chk("rst_run", run_w, 1'b0);
    chk("rst_lap", lap_w, 8'h00);
    chk("rst_ovf", ovf_w, 1'b0);
    cyc(0, 0, 0);
    chk("rst_idle_next", run_w, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
